// File: rtl/ifetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_ctrl_pkg;

    localparam int unsigned IBUS_W = 32;

    localparam logic [IBUS_W-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [IBUS_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [IBUS_W-1:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;

endpackage : ifetch_ctrl_pkg

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues single-outstanding
// bus requests, feeds responses to the branch predictor and holds one
// fetched instruction for decode. Execute redirects flush the front end.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter logic [IBUS_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              jump_flag_i,
    input  logic [IBUS_W-1:0] jump_addr_i,

    output logic              ibus_req_o,
    output logic [IBUS_W-1:0] ibus_addr_o,
    input  logic              ibus_gnt_i,
    input  logic              ibus_rvalid_i,
    input  logic [IBUS_W-1:0] ibus_rdata_i,

    output logic [IBUS_W-1:0] bpu_inst_o,
    output logic              bpu_inst_valid_o,
    output logic [IBUS_W-1:0] bpu_pc_o,
    input  logic              bpu_prdt_taken_i,
    input  logic [IBUS_W-1:0] bpu_prdt_addr_i,

    output logic              inst_valid_o,
    output logic [IBUS_W-1:0] inst_o,
    output logic [IBUS_W-1:0] inst_addr_o,
    output logic              prdt_taken_o,
    input  logic              id_ready_i
);

    fetch_state_e      state_q, state_d;
    logic [IBUS_W-1:0] pc_q, pc_d;
    logic [IBUS_W-1:0] out_pc_q, out_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [IBUS_W-1:0] inst_q, inst_d;
    logic [IBUS_W-1:0] inst_addr_q, inst_addr_d;
    logic              prdt_taken_q, prdt_taken_d;

    logic              req_c;
    logic              accept_c;
    logic              resp_ok_c;

    // Request only when the slot is empty or draining, so a response always lands in an empty slot
    always_comb begin
        req_c     = 1'b0;
        accept_c  = 1'b0;
        resp_ok_c = 1'b0;
        if (state_q == ST_FETCH) begin
            req_c = !inst_valid_q || id_ready_i;
        end
        accept_c  = req_c && ibus_gnt_i;
        resp_ok_c = (state_q == ST_WAIT) && ibus_rvalid_i && !jump_flag_i;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a jump turns any in-flight request into a stale one to drop
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (accept_c) begin
                    state_d = jump_flag_i ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ibus_rvalid_i) begin
                    state_d = ST_FETCH;
                end else if (jump_flag_i) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (ibus_rvalid_i) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: bus request and predictor feed
    always_comb begin
        ibus_req_o       = req_c;
        ibus_addr_o      = {pc_q[IBUS_W-1:2], 2'b00};
        bpu_inst_o       = ibus_rdata_i;
        bpu_inst_valid_o = resp_ok_c;
        bpu_pc_o         = out_pc_q;
        inst_valid_o     = inst_valid_q;
        inst_o           = inst_q;
        inst_addr_o      = inst_addr_q;
        prdt_taken_o     = prdt_taken_q;
    end

    // Datapath next values: PC update, outstanding PC capture, decode slot
    always_comb begin
        pc_d         = pc_q;
        out_pc_d     = out_pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        prdt_taken_d = prdt_taken_q;

        if (accept_c) begin
            out_pc_d = pc_q;
        end

        if (inst_valid_q && id_ready_i) begin
            inst_valid_d = 1'b0;
        end

        if (resp_ok_c) begin
            inst_d       = ibus_rdata_i;
            inst_addr_d  = out_pc_q;
            prdt_taken_d = bpu_prdt_taken_i;
            inst_valid_d = 1'b1;
            pc_d         = bpu_prdt_taken_i ? bpu_prdt_addr_i
                                            : IBUS_W'(out_pc_q + PC_STEP);
        end

        if (jump_flag_i) begin
            pc_d         = jump_addr_i;
            inst_valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            out_pc_q     <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            inst_addr_q  <= '0;
            prdt_taken_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            out_pc_q     <= out_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            prdt_taken_q <= prdt_taken_d;
        end
    end

endmodule : ifetch_ctrl

// File: tb/tb_ifetch_ctrl.sv
// Directed cycle-by-cycle vectors for the instruction-fetch sequencer.
module tb_ifetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0080;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] I1     = 32'h1111_1111;
    localparam logic [31:0] I2     = 32'h2222_2222;
    localparam logic [31:0] I3     = 32'h3333_3333;
    localparam logic [31:0] I4     = 32'h4444_4444;
    localparam logic [31:0] I5     = 32'h5555_5555;
    localparam logic [31:0] STALE  = 32'hDEAD_BEEF;
    localparam logic [31:0] JUNK   = 32'hBADB_AD00;
    localparam int          NVEC   = 25;

    logic        clk;
    logic        rst_n;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] bpu_inst_o;
    logic        bpu_inst_valid_o;
    logic [31:0] bpu_pc_o;
    logic        bpu_prdt_taken_i;
    logic [31:0] bpu_prdt_addr_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        prdt_taken_o;
    logic        id_ready_i;

    int n_pass;
    int n_total;

    typedef struct {
        logic        jmp;
        logic [31:0] jaddr;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        pt;
        logic [31:0] paddr;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_iaddr;
        logic        e_ipt;
        logic        e_bv;
        logic [31:0] e_bpc;
    } vec_t;

    vec_t vecs [NVEC];

    ifetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .jump_flag_i      (jump_flag_i),
        .jump_addr_i      (jump_addr_i),
        .ibus_req_o       (ibus_req_o),
        .ibus_addr_o      (ibus_addr_o),
        .ibus_gnt_i       (ibus_gnt_i),
        .ibus_rvalid_i    (ibus_rvalid_i),
        .ibus_rdata_i     (ibus_rdata_i),
        .bpu_inst_o       (bpu_inst_o),
        .bpu_inst_valid_o (bpu_inst_valid_o),
        .bpu_pc_o         (bpu_pc_o),
        .bpu_prdt_taken_i (bpu_prdt_taken_i),
        .bpu_prdt_addr_i  (bpu_prdt_addr_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .inst_addr_o      (inst_addr_o),
        .prdt_taken_o     (prdt_taken_o),
        .id_ready_i       (id_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic jmp, input logic [31:0] jaddr, input logic gnt, input logic rv,
        input logic [31:0] rdata, input logic pt, input logic [31:0] paddr, input logic rdy,
        input logic e_req, input logic [31:0] e_addr, input logic e_iv, input logic [31:0] e_inst,
        input logic [31:0] e_iaddr, input logic e_ipt, input logic e_bv, input logic [31:0] e_bpc);
        vec_t v;
        v.jmp = jmp;     v.jaddr = jaddr;   v.gnt = gnt;       v.rv = rv;
        v.rdata = rdata; v.pt = pt;         v.paddr = paddr;   v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;     v.e_inst = e_inst;
        v.e_iaddr = e_iaddr; v.e_ipt = e_ipt; v.e_bv = e_bv;  v.e_bpc = e_bpc;
        return v;
    endfunction

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input vec_t v);
        jump_flag_i      = v.jmp;
        jump_addr_i      = v.jaddr;
        ibus_gnt_i       = v.gnt;
        ibus_rvalid_i    = v.rv;
        ibus_rdata_i     = v.rdata;
        bpu_prdt_taken_i = v.pt;
        bpu_prdt_addr_i  = v.paddr;
        id_ready_i       = v.rdy;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        //          jmp jaddr         gnt rv rdata pt paddr   rdy | req addr         iv inst iaddr        ipt bv bpc
        vecs[0]  = mk(0, 32'h0,        0, 0, 0,     0, 32'h0,   1,  0, RST_PC,       0, NOP, 32'h0,       0, 0, 32'h0);
        vecs[1]  = mk(0, 32'h0,        1, 0, 0,     0, 32'h0,   1,  1, RST_PC,       0, NOP, 32'h0,       0, 0, 32'h0);
        vecs[2]  = mk(0, 32'h0,        0, 1, I1,    0, 32'h0,   1,  0, RST_PC,       0, NOP, 32'h0,       0, 1, RST_PC);
        vecs[3]  = mk(0, 32'h0,        1, 0, 0,     0, 32'h0,   1,  1, 32'h84,       1, I1,  32'h80,      0, 0, 32'h0);
        vecs[4]  = mk(0, 32'h0,        0, 1, I2,    1, 32'h200, 1,  0, 32'h84,       0, I1,  32'h80,      0, 1, 32'h84);
        vecs[5]  = mk(0, 32'h0,        1, 0, 0,     0, 32'h0,   1,  1, 32'h200,      1, I2,  32'h84,      1, 0, 32'h0);
        // jump while waiting, then stale response with a bogus prediction
        vecs[6]  = mk(1, 32'h1000,     0, 0, 0,     0, 32'h0,   1,  0, 32'h200,      0, I2,  32'h84,      1, 0, 32'h0);
        vecs[7]  = mk(0, 32'h0,        0, 0, 0,     0, 32'h0,   1,  0, 32'h1000,     0, I2,  32'h84,      1, 0, 32'h0);
        vecs[8]  = mk(0, 32'h0,        0, 1, STALE, 1, 32'h500, 1,  0, 32'h1000,     0, I2,  32'h84,      1, 0, 32'h0);
        vecs[9]  = mk(0, 32'h0,        1, 0, 0,     0, 32'h0,   1,  1, 32'h1000,     0, I2,  32'h84,      1, 0, 32'h0);
        vecs[10] = mk(0, 32'h0,        0, 1, I3,    0, 32'h0,   1,  0, 32'h1000,     0, I2,  32'h84,      1, 1, 32'h1000);
        // decode stalls for five cycles; stray rvalid in FETCH is ignored
        vecs[11] = mk(0, 32'h0,        1, 0, 0,     0, 32'h0,   0,  0, 32'h1004,     1, I3,  32'h1000,    0, 0, 32'h0);
        vecs[12] = mk(0, 32'h0,        1, 1, JUNK,  1, 32'h700, 0,  0, 32'h1004,     1, I3,  32'h1000,    0, 0, 32'h0);
        vecs[13] = mk(0, 32'h0,        1, 0, 0,     0, 32'h0,   0,  0, 32'h1004,     1, I3,  32'h1000,    0, 0, 32'h0);
        vecs[14] = mk(0, 32'h0,        1, 0, 0,     0, 32'h0,   0,  0, 32'h1004,     1, I3,  32'h1000,    0, 0, 32'h0);
        vecs[15] = mk(0, 32'h0,        1, 0, 0,     0, 32'h0,   0,  0, 32'h1004,     1, I3,  32'h1000,    0, 0, 32'h0);
        vecs[16] = mk(0, 32'h0,        1, 0, 0,     0, 32'h0,   1,  1, 32'h1004,     1, I3,  32'h1000,    0, 0, 32'h0);
        // jump coincident with rvalid, unaligned target
        vecs[17] = mk(1, 32'h102,      0, 1, I4,    0, 32'h0,   1,  0, 32'h1004,     0, I3,  32'h1000,    0, 0, 32'h0);
        // ungranted request retargeted by a second jump
        vecs[18] = mk(1, 32'hFFFFFFFC, 0, 0, 0,     0, 32'h0,   1,  1, 32'h100,      0, I3,  32'h1000,    0, 0, 32'h0);
        vecs[19] = mk(0, 32'h0,        1, 0, 0,     0, 32'h0,   1,  1, 32'hFFFFFFFC, 0, I3,  32'h1000,    0, 0, 32'h0);
        vecs[20] = mk(0, 32'h0,        0, 1, I5,    0, 32'h0,   1,  0, 32'hFFFFFFFC, 0, I3,  32'h1000,    0, 1, 32'hFFFFFFFC);
        // PC wrapped to zero; jump in the same cycle as a grant
        vecs[21] = mk(1, 32'h300,      1, 0, 0,     0, 32'h0,   1,  1, 32'h0,        1, I5,  32'hFFFFFFFC, 0, 0, 32'h0);
        vecs[22] = mk(0, 32'h0,        0, 0, 0,     0, 32'h0,   1,  0, 32'h300,      0, I5,  32'hFFFFFFFC, 0, 0, 32'h0);
        vecs[23] = mk(0, 32'h0,        0, 1, STALE, 0, 32'h0,   1,  0, 32'h300,      0, I5,  32'hFFFFFFFC, 0, 0, 32'h0);
        vecs[24] = mk(0, 32'h0,        0, 0, 0,     0, 32'h0,   1,  1, 32'h300,      0, I5,  32'hFFFFFFFC, 0, 0, 32'h0);

        rst_n = 1'b0;
        drive(vecs[0]);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            #1;
            chk("ibus_req",   i, 32'(ibus_req_o),       32'(vecs[i].e_req));
            chk("ibus_addr",  i, ibus_addr_o,            vecs[i].e_addr);
            chk("inst_valid", i, 32'(inst_valid_o),     32'(vecs[i].e_iv));
            chk("inst",       i, inst_o,                 vecs[i].e_inst);
            chk("inst_addr",  i, inst_addr_o,            vecs[i].e_iaddr);
            chk("prdt_taken", i, 32'(prdt_taken_o),     32'(vecs[i].e_ipt));
            chk("bpu_valid",  i, 32'(bpu_inst_valid_o), 32'(vecs[i].e_bv));
            chk("bpu_inst",   i, bpu_inst_o,             vecs[i].rdata);
            if (vecs[i].e_bv) begin
                chk("bpu_pc", i, bpu_pc_o, vecs[i].e_bpc);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // asynchronous reset mid-operation, away from any clock edge
        drive(mk(0, 32'h0, 1, 0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req",        100, 32'(ibus_req_o),   32'h0);
        chk("rst_addr",       100, ibus_addr_o,        RST_PC);
        chk("rst_inst_valid", 100, 32'(inst_valid_o), 32'h0);
        chk("rst_inst",       100, inst_o,             NOP);
        chk("rst_inst_addr",  100, inst_addr_o,        32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle_req", 101, 32'(ibus_req_o), 32'h0);
        @(negedge clk);
        #1;
        chk("post_rst_req",  102, 32'(ibus_req_o), 32'h1);
        chk("post_rst_addr", 102, ibus_addr_o,      RST_PC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ifetch_ctrl
